// File: rtl/sti_req_arbiter.sv
// Round-robin command scheduler for the STI_DAC serializer core.
// Two private command FIFOs feed a frame-at-a-time issue FSM that watches so_valid.

module sti_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 21
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
endmodule

module sti_req_arbiter #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [20:0] req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [20:0] req1_cmd,
  input  logic        end_req,
  input  logic        so_valid,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  output logic        grant_id,
  output logic        busy,
  output logic [7:0]  frame_cnt,
  output logic        err_timeout,
  output logic        err_len,
  output logic        all_done
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP, END_ISSUE, DONE
  } state_t;

  state_t        state_q;
  logic          load_q, pi_fill_q, pi_msb_q, pi_low_q, pi_end_q;
  logic [15:0]   pi_data_q;
  logic [1:0]    pi_length_q;
  logic          grant_q, last_grant_q, end_pend_q;
  logic [5:0]    bitcnt_q;
  logic [TW-1:0] tocnt_q;
  logic [7:0]    frame_cnt_q;
  logic          err_timeout_q, err_len_q, all_done_q;

  logic        empty0, empty1, full0, full1;
  logic        push0, push1, pop0, pop1, pick1;
  logic [20:0] data0, data1, cmd_sel;
  logic [5:0]  exp_bits;

  // Readiness depends only on registered occupancy, so a same-cycle pop never raises it.
  assign req0_ready = !full0 && !all_done_q;
  assign req1_ready = !full1 && !all_done_q;
  assign push0      = req0_valid && req0_ready;
  assign push1      = req1_valid && req1_ready;

  always_comb begin
    pick1    = !empty1 && (empty0 || !last_grant_q);
    pop0     = (state_q == IDLE) && !empty0 && !pick1;
    pop1     = (state_q == IDLE) && pick1;
    cmd_sel  = pick1 ? data1 : data0;
    exp_bits = {({1'b0, pi_length_q} + 3'd1), 3'b000};
  end

  sti_req_fifo #(.DEPTH(DEPTH), .W(21)) u_fifo0 (
    .clk_i(clk), .reset_i(reset), .push_i(push0), .data_i(req0_cmd),
    .pop_i(pop0), .data_o(data0), .empty_o(empty0), .full_o(full0)
  );

  sti_req_fifo #(.DEPTH(DEPTH), .W(21)) u_fifo1 (
    .clk_i(clk), .reset_i(reset), .push_i(push1), .data_i(req1_cmd),
    .pop_i(pop1), .data_o(data1), .empty_o(empty1), .full_o(full1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      load_q        <= 1'b0;
      pi_data_q     <= '0;
      pi_length_q   <= '0;
      pi_fill_q     <= 1'b0;
      pi_msb_q      <= 1'b0;
      pi_low_q      <= 1'b0;
      pi_end_q      <= 1'b0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      end_pend_q    <= 1'b0;
      bitcnt_q      <= '0;
      tocnt_q       <= '0;
      frame_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
      err_len_q     <= 1'b0;
      all_done_q    <= 1'b0;
    end else begin
      if (end_req && !all_done_q) end_pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pop0 || pop1) begin
            pi_data_q    <= cmd_sel[15:0];
            pi_length_q  <= cmd_sel[17:16];
            pi_fill_q    <= cmd_sel[18];
            pi_msb_q     <= cmd_sel[19];
            pi_low_q     <= cmd_sel[20];
            pi_end_q     <= 1'b0;
            grant_q      <= pick1;
            last_grant_q <= pick1;
            load_q       <= 1'b1;
            state_q      <= ISSUE;
          end else if (end_pend_q) begin
            load_q     <= 1'b1;
            pi_end_q   <= 1'b1;
            all_done_q <= 1'b1;
            end_pend_q <= 1'b0;
            state_q    <= END_ISSUE;
          end
        end
        ISSUE: begin
          load_q   <= 1'b0;
          bitcnt_q <= '0;
          tocnt_q  <= '0;
          state_q  <= WAIT_START;
        end
        WAIT_START: begin
          if (so_valid) begin
            bitcnt_q <= 6'd1;
            state_q  <= WAIT_DONE;
          end else if (tocnt_q == TW'(TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            state_q       <= GAP;
          end else begin
            tocnt_q <= tocnt_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (so_valid) begin
            bitcnt_q <= bitcnt_q + 6'd1;
          end else begin
            if (bitcnt_q != exp_bits) err_len_q <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 8'd1;
            state_q     <= GAP;
          end
        end
        GAP:       state_q <= IDLE;
        END_ISSUE: begin
          load_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE:      state_q <= DONE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign load        = load_q;
  assign pi_data     = pi_data_q;
  assign pi_length   = pi_length_q;
  assign pi_fill     = pi_fill_q;
  assign pi_msb      = pi_msb_q;
  assign pi_low      = pi_low_q;
  assign pi_end      = pi_end_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign frame_cnt   = frame_cnt_q;
  assign err_timeout = err_timeout_q;
  assign err_len     = err_len_q;
  assign all_done    = all_done_q;
endmodule
